// File: rtl/drum_command_scheduler_if.sv
// Bus between the drum command scheduler and its environment: sensor hits in,
// single-command trigger path toward the SPI slave out, plus status counters.
interface drum_command_scheduler_if #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  logic [NUM_CH-1:0]            hit;
  logic                         command_sent;
  logic                         drum_trigger_valid;
  logic [3:0]                   drum_code;
  logic                         busy;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic [7:0]                   drop_count;
  logic [7:0]                   timeout_count;

  modport master (
    input  hit,
    input  command_sent,
    output drum_trigger_valid,
    output drum_code,
    output busy,
    output fifo_count,
    output drop_count,
    output timeout_count
  );

  modport slave (
    output hit,
    output command_sent,
    input  drum_trigger_valid,
    input  drum_code,
    input  busy,
    input  fifo_count,
    input  drop_count,
    input  timeout_count
  );
endinterface

// File: rtl/drum_command_scheduler.sv
// Edge-detects drum hits, arbitrates round-robin into a small FIFO and issues one
// command at a time, waiting for ack or timeout. Optional macro: DRUM_SCHED_RETRY_EN.
module drum_command_scheduler #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  drum_command_scheduler_if.master bus
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWaitAck = 2'd1;
  localparam logic [1:0] StGap     = 2'd2;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input int b);
    int s;
    s = int'(a) + b;
    return (s > 255) ? 8'hFF : s[7:0];
  endfunction

  // Edge detect, pending and arbitration
  logic [NUM_CH-1:0] hit_prev_q, pending_q, pending_d;
  logic [NUM_CH-1:0] rise, clear_mask, coalesce;
  logic [3:0]        last_grant_q, grant_idx;
  logic              grant_vld;
  int unsigned       rr_idx;

  // FIFO
  logic [3:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop, full;

  // Command FSM
  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              valid_q, valid_d;
  logic [3:0]        code_q, code_d;
  logic [7:0]        drop_q, drop_d, tout_q, tout_d;
  int                tout_inc, fsm_drop;
`ifdef DRUM_SCHED_RETRY_EN
  logic              retried_q, retried_d;
`endif

  assign rise = bus.hit & ~hit_prev_q;

  // Search starts just past the previous winner so every channel gets a turn.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      rr_idx = (32'(last_grant_q) + off) % NUM_CH;
      if (!grant_vld && pending_q[rr_idx]) begin
        grant_vld = 1'b1;
        grant_idx = 4'(rr_idx);
      end
    end
  end

  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = (state_q == StIdle) && (count_q != '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = grant_vld && (!full || pop);

  always_comb begin
    clear_mask = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      clear_mask[ch] = push && (grant_idx == 4'(ch));
    end
  end

  // An edge that lands on the bit being cleared re-arms it without a drop.
  assign coalesce  = rise & pending_q & ~clear_mask;
  assign pending_d = (pending_q & ~clear_mask) | rise;

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    gap_d    = gap_q;
    valid_d  = 1'b0;
    code_d   = code_q;
    tout_inc = 0;
    fsm_drop = 0;
`ifdef DRUM_SCHED_RETRY_EN
    retried_d = retried_q;
`endif
    case (state_q)
      StIdle: begin
        if (pop) begin
          code_d  = mem[rd_ptr_q];
          valid_d = 1'b1;
          timer_d = '0;
          state_d = StWaitAck;
`ifdef DRUM_SCHED_RETRY_EN
          retried_d = 1'b0;
`endif
        end
      end
      StWaitAck: begin
        if (bus.command_sent) begin
          state_d = StGap;
          gap_d   = '0;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
`ifdef DRUM_SCHED_RETRY_EN
          if (!retried_q) begin
            valid_d   = 1'b1;
            timer_d   = '0;
            retried_d = 1'b1;
          end else begin
            tout_inc = 1;
            fsm_drop = 1;
            state_d  = StGap;
            gap_d    = '0;
          end
`else
          tout_inc = 1;
          state_d  = StGap;
          gap_d    = '0;
`endif
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign tout_d = sat_add(tout_q, tout_inc);
  assign drop_d = sat_add(drop_q, $countones(coalesce) + fsm_drop);

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_prev_q   <= '0;
      pending_q    <= '0;
      last_grant_q <= 4'(NUM_CH - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= StIdle;
      timer_q      <= '0;
      gap_q        <= '0;
      valid_q      <= 1'b0;
      code_q       <= '0;
      drop_q       <= '0;
      tout_q       <= '0;
`ifdef DRUM_SCHED_RETRY_EN
      retried_q    <= 1'b0;
`endif
    end else begin
      hit_prev_q <= bus.hit;
      pending_q  <= pending_d;
      if (push) begin
        last_grant_q <= grant_idx;
        wr_ptr_q     <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q   <= count_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      drop_q    <= drop_d;
      tout_q    <= tout_d;
`ifdef DRUM_SCHED_RETRY_EN
      retried_q <= retried_d;
`endif
    end
  end

  assign bus.drum_trigger_valid = valid_q;
  assign bus.drum_code          = code_q;
  assign bus.busy               = (state_q != StIdle) || (count_q != '0) || (|pending_q);
  assign bus.fifo_count         = count_q;
  assign bus.drop_count         = drop_q;
  assign bus.timeout_count      = tout_q;

endmodule

// File: tb/tb_drum_command_scheduler.sv
// Directed bench for drum_command_scheduler: latency, arbitration order, FIFO overflow,
// ack timeout (with and without DRUM_SCHED_RETRY_EN) and mid-command reset.
module tb_drum_command_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  drum_command_scheduler_if #(.NUM_CH(8), .FIFO_DEPTH(4)) bus ();

  drum_command_scheduler #(
    .NUM_CH      (8),
    .FIFO_DEPTH  (4),
    .ACK_TIMEOUT (16),
    .GAP_CYCLES  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    bus.hit          = '0;
    bus.command_sent = 1'b0;
    steps(2);
    rst_n = 1'b1;
    step();
  endtask

  // Steps until a valid pulse is observed, bounded.
  task automatic wait_valid(input string tag, output logic [3:0] code);
    int n = 0;
    while (!bus.drum_trigger_valid && n < 200) begin
      step();
      n++;
    end
    check_eq({tag, "_seen"}, 32'(bus.drum_trigger_valid), 32'd1);
    code = bus.drum_code;
  endtask

  task automatic ack_now();
    bus.command_sent = 1'b1;
    step();
    bus.command_sent = 1'b0;
  endtask

  initial begin
    logic [3:0] code;
    logic [3:0] exp_a [3];
    logic [3:0] exp_b [3];
    int         vcount;

    // Reset state
    rst_n            = 1'b0;
    bus.hit          = '0;
    bus.command_sent = 1'b0;
    steps(2);
    check_eq("rst_valid", 32'(bus.drum_trigger_valid), 32'd0);
    check_eq("rst_code", 32'(bus.drum_code), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_fifo", 32'(bus.fifo_count), 32'd0);
    check_eq("rst_drop", 32'(bus.drop_count), 32'd0);
    check_eq("rst_tout", 32'(bus.timeout_count), 32'd0);
    rst_n = 1'b1;
    step();

    // Single hit on ch3: pending, pushed, popped; valid 3 cycles after the edge
    bus.hit = 8'h08;
    step();
    bus.hit = 8'h00;
    check_eq("t1_busy_pending", 32'(bus.busy), 32'd1);
    check_eq("t1_valid_e0", 32'(bus.drum_trigger_valid), 32'd0);
    step();
    check_eq("t1_fifo_e1", 32'(bus.fifo_count), 32'd1);
    check_eq("t1_valid_e1", 32'(bus.drum_trigger_valid), 32'd0);
    step();
    check_eq("t1_valid_e2", 32'(bus.drum_trigger_valid), 32'd1);
    check_eq("t1_code", 32'(bus.drum_code), 32'd3);
    check_eq("t1_fifo_e2", 32'(bus.fifo_count), 32'd0);
    steps(5);
    check_eq("t1_one_pulse", 32'(bus.drum_trigger_valid), 32'd0);
    ack_now();
    steps(3);
    check_eq("t1_busy_gap", 32'(bus.busy), 32'd1);
    step();
    check_eq("t1_busy_idle", 32'(bus.busy), 32'd0);
    check_eq("t1_code_hold", 32'(bus.drum_code), 32'd3);

    // Simultaneous edges on 0,5,7 from reset: issue order 0,5,7
    do_reset();
    exp_a[0] = 4'd0; exp_a[1] = 4'd5; exp_a[2] = 4'd7;
    bus.hit = 8'hA1;
    step();
    bus.hit = 8'h00;
    for (int i = 0; i < 3; i++) begin
      wait_valid("t2_order", code);
      check_eq("t2_order_code", 32'(code), 32'(exp_a[i]));
      ack_now();
    end

    // After a grant of 5, a burst on 2,4,6 is searched from 6: order 6,2,4
    do_reset();
    exp_b[0] = 4'd6; exp_b[1] = 4'd2; exp_b[2] = 4'd4;
    bus.hit = 8'h20;
    step();
    bus.hit = 8'h00;
    wait_valid("t2_ch5", code);
    check_eq("t2_ch5_code", 32'(code), 32'd5);
    ack_now();
    bus.hit = 8'h54;
    step();
    bus.hit = 8'h00;
    for (int i = 0; i < 3; i++) begin
      wait_valid("t2_rr", code);
      check_eq("t2_rr_code", 32'(code), 32'(exp_b[i]));
      ack_now();
    end

    // FIFO overflow with acks withheld
    do_reset();
    bus.hit = 8'hFF;
    step();
    bus.hit = 8'h00;
    step();
    step();
    check_eq("t3_first_valid", 32'(bus.drum_trigger_valid), 32'd1);
    check_eq("t3_first_code", 32'(bus.drum_code), 32'd0);
    steps(4);
    check_eq("t3_fifo_full", 32'(bus.fifo_count), 32'd4);
    bus.hit = 8'h40;
    step();
    bus.hit = 8'h00;
    step();
    check_eq("t3_drop", 32'(bus.drop_count), 32'd1);
    check_eq("t3_fifo_still_full", 32'(bus.fifo_count), 32'd4);
    ack_now();
    for (int i = 1; i < 8; i++) begin
      wait_valid("t3_drain", code);
      check_eq("t3_drain_code", 32'(code), 32'(i));
      ack_now();
    end
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.drum_trigger_valid) vcount++;
    end
    check_eq("t3_no_extra", 32'(vcount), 32'd0);
    check_eq("t3_busy_done", 32'(bus.busy), 32'd0);
    check_eq("t3_tout", 32'(bus.timeout_count), 32'd0);

    // No ack: timeout, then the next queued command goes out
    do_reset();
    bus.hit = 8'h06;
    step();
    bus.hit = 8'h00;
    wait_valid("t4_first", code);
    check_eq("t4_first_code", 32'(code), 32'd1);
`ifdef DRUM_SCHED_RETRY_EN
    steps(16);
    check_eq("t4_retry_valid", 32'(bus.drum_trigger_valid), 32'd1);
    check_eq("t4_retry_code", 32'(bus.drum_code), 32'd1);
    check_eq("t4_retry_tout", 32'(bus.timeout_count), 32'd0);
`endif
    steps(15);
    check_eq("t4_tout_before", 32'(bus.timeout_count), 32'd0);
    step();
    check_eq("t4_tout_after", 32'(bus.timeout_count), 32'd1);
`ifdef DRUM_SCHED_RETRY_EN
    check_eq("t4_drop", 32'(bus.drop_count), 32'd1);
`else
    check_eq("t4_drop", 32'(bus.drop_count), 32'd0);
`endif
    steps(5);
    check_eq("t4_next_valid", 32'(bus.drum_trigger_valid), 32'd1);
    check_eq("t4_next_code", 32'(bus.drum_code), 32'd2);
    ack_now();

    // Ack coincident with the final timeout cycle: ack wins
    do_reset();
    bus.hit = 8'h10;
    step();
    bus.hit = 8'h00;
    wait_valid("t5_first", code);
    check_eq("t5_code", 32'(code), 32'd4);
`ifdef DRUM_SCHED_RETRY_EN
    steps(16);
    check_eq("t5_retry_valid", 32'(bus.drum_trigger_valid), 32'd1);
`endif
    steps(15);
    ack_now();
    check_eq("t5_tout", 32'(bus.timeout_count), 32'd0);
    check_eq("t5_drop", 32'(bus.drop_count), 32'd0);
    steps(4);
    check_eq("t5_busy", 32'(bus.busy), 32'd0);

    // Reset during WAIT_ACK with two commands queued
    do_reset();
    bus.hit = 8'h07;
    step();
    bus.hit = 8'h00;
    steps(3);
    check_eq("t6_fifo_before", 32'(bus.fifo_count), 32'd2);
    check_eq("t6_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_fifo", 32'(bus.fifo_count), 32'd0);
    check_eq("t6_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("t6_rst_code", 32'(bus.drum_code), 32'd0);
    check_eq("t6_rst_valid", 32'(bus.drum_trigger_valid), 32'd0);
    step();
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.drum_trigger_valid) vcount++;
    end
    check_eq("t6_quiet", 32'(vcount), 32'd0);
    bus.hit = 8'h40;
    step();
    bus.hit = 8'h00;
    steps(2);
    check_eq("t6_fresh_valid", 32'(bus.drum_trigger_valid), 32'd1);
    check_eq("t6_fresh_code", 32'(bus.drum_code), 32'd6);
    ack_now();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
